// File: rtl/dna_seq_loader.sv
// dna_seq_loader: packs an ASCII A/C/G/T stream into 2-bit codes written to sequence memory
module dna_seq_loader #(
    parameter int         ADDR_W    = 16,
    parameter logic [7:0] TERM_CHAR = 8'h0A,
    parameter bit         ALLOW_LC  = 1'b1
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic              in_valid_i,
    input  logic [7:0]        in_char_i,
    output logic              in_ready_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [1:0]        mem_data_o,
    output logic              ready_o,
    output logic [ADDR_W-1:0] dna_length_o,
    output logic              error_o,
    output logic [1:0]        err_code_o
);
    typedef enum logic [1:0] {IDLE, LOAD, DONE, ERR} state_t;

    localparam logic [ADDR_W-1:0] MAX_CNT = '1;

    state_t            state_q;
    logic [ADDR_W-1:0] count_q;
    logic [7:0]        uc_char;
    logic              is_nuc;
    logic              is_term;
    logic              accept;
    logic [1:0]        code;

    // Fold accepted lowercase letters, classify the offered char and qualify the handshake
    always_comb begin
        uc_char = (ALLOW_LC && (in_char_i inside {8'h61, 8'h63, 8'h67, 8'h74})) ? (in_char_i & 8'hDF) : in_char_i;
        is_nuc  = uc_char inside {8'h41, 8'h43, 8'h47, 8'h54};
        is_term = in_char_i == TERM_CHAR;
        code    = (uc_char == 8'h43) ? 2'b01 : (uc_char == 8'h47) ? 2'b10 : (uc_char == 8'h54) ? 2'b11 : 2'b00;
        accept  = (state_q == LOAD) && in_ready_o && in_valid_i && !start_i;
    end

    // Load FSM with registered outputs; start restarts from any state and beats in_valid
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q      <= IDLE;
            count_q      <= '0;
            in_ready_o   <= 1'b0;
            mem_we_o     <= 1'b0;
            mem_addr_o   <= '0;
            mem_data_o   <= 2'b00;
            ready_o      <= 1'b0;
            dna_length_o <= '0;
            error_o      <= 1'b0;
            err_code_o   <= 2'b00;
        end else begin
            mem_we_o <= 1'b0;
            ready_o  <= 1'b0;
            if (start_i) begin
                state_q      <= LOAD;
                count_q      <= '0;
                in_ready_o   <= 1'b0;
                dna_length_o <= '0;
                error_o      <= 1'b0;
                err_code_o   <= 2'b00;
            end else if (state_q == LOAD) begin
                in_ready_o <= 1'b1;
                if (accept) begin
                    if (is_nuc && count_q != MAX_CNT) begin
                        mem_we_o   <= 1'b1;
                        mem_addr_o <= count_q;
                        mem_data_o <= code;
                        count_q    <= count_q + 1'b1;
                    end else if (is_term && count_q != '0) begin
                        state_q      <= DONE;
                        in_ready_o   <= 1'b0;
                        ready_o      <= 1'b1;
                        dna_length_o <= count_q;
                    end else begin
                        state_q      <= ERR;
                        in_ready_o   <= 1'b0;
                        error_o      <= 1'b1;
                        dna_length_o <= count_q;
                        err_code_o   <= is_nuc ? 2'b10 : is_term ? 2'b11 : 2'b01;
                    end
                end
            end else begin
                in_ready_o <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_dna_seq_loader.sv
// tb_dna_seq_loader: checks two loaders (lowercase allowed / rejected) against a sequence-level model
module tb_dna_seq_loader;
    localparam int MAXLEN = 15;

    logic       clk = 1'b0;
    logic       rst, start, in_valid;
    logic [7:0] in_char;

    logic       ir_o   [2];
    logic       we_o   [2];
    logic [3:0] addr_o [2];
    logic [1:0] data_o [2];
    logic       rdy_o  [2];
    logic [3:0] len_o  [2];
    logic       err_o  [2];
    logic [1:0] ec_o   [2];

    int checks = 0;
    int errors = 0;

    int ph[2], cnt[2], m_addr[2], m_data[2], m_len[2], m_ec[2];
    bit m_ir[2], m_we[2], m_rdy[2], m_err[2];
    bit acc0;

    always #5 clk = ~clk;

    dna_seq_loader #(.ADDR_W(4), .TERM_CHAR(8'h0A), .ALLOW_LC(1'b1)) dut_lc (
        .clock_i(clk), .reset_i(rst), .start_i(start), .in_valid_i(in_valid), .in_char_i(in_char),
        .in_ready_o(ir_o[0]), .mem_we_o(we_o[0]), .mem_addr_o(addr_o[0]), .mem_data_o(data_o[0]),
        .ready_o(rdy_o[0]), .dna_length_o(len_o[0]), .error_o(err_o[0]), .err_code_o(ec_o[0])
    );

    dna_seq_loader #(.ADDR_W(4), .TERM_CHAR(8'h0A), .ALLOW_LC(1'b0)) dut_uc (
        .clock_i(clk), .reset_i(rst), .start_i(start), .in_valid_i(in_valid), .in_char_i(in_char),
        .in_ready_o(ir_o[1]), .mem_we_o(we_o[1]), .mem_addr_o(addr_o[1]), .mem_data_o(data_o[1]),
        .ready_o(rdy_o[1]), .dna_length_o(len_o[1]), .error_o(err_o[1]), .err_code_o(ec_o[1])
    );

    // 0..3 nucleotide code, 4 terminator, 5 anything else
    function automatic int kind(input logic [7:0] c, input bit lc);
        string s = "ACGT";
        for (int i = 0; i < 4; i++)
            if (c == s[i] || (lc && c == (s[i] | 8'h20))) return i;
        return (c == 8'h0A) ? 4 : 5;
    endfunction

    task automatic chk(input string tag, input int inst, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s[%0d] observed %0h expected %0h", tag, inst, obs, exp);
        end
    endtask

    // ph: 0 idle, 1 loading, 2 finished (sequence complete or aborted)
    task automatic model_step(input int i, input bit r, input bit s, input bit v, input logic [7:0] c);
        bit acc = v && m_ir[i] && !s;
        int k = kind(c, i == 0);
        m_we[i] = 0;
        m_rdy[i] = 0;
        if (r) begin
            ph[i] = 0; cnt[i] = 0; m_ir[i] = 0; m_addr[i] = 0; m_data[i] = 0;
            m_len[i] = 0; m_err[i] = 0; m_ec[i] = 0;
        end else if (s) begin
            ph[i] = 1; cnt[i] = 0; m_ir[i] = 0; m_len[i] = 0; m_err[i] = 0; m_ec[i] = 0;
        end else begin
            if (acc) begin
                if (k < 4 && cnt[i] < MAXLEN) begin
                    m_we[i] = 1; m_addr[i] = cnt[i]; m_data[i] = k; cnt[i]++;
                end else begin
                    ph[i] = 2;
                    m_len[i] = cnt[i];
                    if (k == 4 && cnt[i] > 0) m_rdy[i] = 1;
                    else begin
                        m_err[i] = 1;
                        m_ec[i] = (k < 4) ? 2 : (k == 4) ? 3 : 1;
                    end
                end
            end
            m_ir[i] = ph[i] == 1;
        end
        if (i == 0) acc0 = acc && !r;
    endtask

    task automatic cyc(input bit r, input bit s, input bit v, input logic [7:0] c);
        rst = r; start = s; in_valid = v; in_char = c;
        @(posedge clk);
        for (int i = 0; i < 2; i++) model_step(i, r, s, v, c);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("in_ready", i, ir_o[i], m_ir[i]);
            chk("mem_we", i, we_o[i], m_we[i]);
            chk("mem_addr", i, addr_o[i], m_addr[i]);
            chk("mem_data", i, data_o[i], m_data[i]);
            chk("ready", i, rdy_o[i], m_rdy[i]);
            chk("dna_length", i, len_o[i], m_len[i]);
            chk("error", i, err_o[i], m_err[i]);
            chk("err_code", i, ec_o[i], m_ec[i]);
        end
    endtask

    task automatic send(input logic [7:0] c, input int gap);
        repeat (gap) cyc(0, 0, 0, c);
        for (int n = 0; ; n++) begin
            cyc(0, 0, 1, c);
            if (acc0) break;
            if (n == 40) begin
                chk("accept_timeout", 0, acc0, 1);
                break;
            end
        end
    endtask

    task automatic send_str(input string s, input int gap);
        for (int j = 0; j < s.len(); j++) begin
            if (ph[0] != 1) break;
            send(s[j], gap);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        string alpha = "ACGTacgtACGTACGTxN";
        for (int i = 0; i < 2; i++) model_step(i, 1, 0, 0, 8'h00);
        cyc(1, 0, 0, 8'h00);
        cyc(1, 0, 0, 8'h00);
        cyc(0, 0, 1, "A");
        chk("idle_in_ready", 0, ir_o[0], 0);

        cyc(0, 1, 0, 8'h00);
        send_str("ACGT\n", 0);
        chk("t1_ready", 0, rdy_o[0], 1);
        chk("t1_len", 0, len_o[0], 4);
        cyc(0, 0, 0, 8'h00);
        chk("t1_ready_low", 0, rdy_o[0], 0);

        cyc(0, 1, 0, 8'h00);
        send_str("aG\n", 0);
        chk("t2_len_lc", 0, len_o[0], 2);
        chk("t2_err_uc", 1, err_o[1], 1);
        chk("t2_code_uc", 1, ec_o[1], 1);

        cyc(0, 1, 0, 8'h00);
        send_str("\n", 0);
        chk("t3_err", 0, err_o[0], 1);
        chk("t3_code", 0, ec_o[0], 3);

        cyc(0, 1, 0, 8'h00);
        send_str("CCCCCCCCCCCCCCCC", 0);
        chk("t4_len", 0, len_o[0], 15);
        chk("t4_code", 0, ec_o[0], 2);

        cyc(0, 1, 0, 8'h00);
        send_str("AC", 0);
        cyc(0, 1, 0, 8'h00);
        send_str("G\n", 0);
        chk("t5_len", 0, len_o[0], 1);
        chk("t5_addr", 0, addr_o[0], 0);
        chk("t5_data", 0, data_o[0], 2);

        cyc(0, 1, 0, 8'h00);
        send_str("TG", 2);
        cyc(1, 0, 1, "C");
        chk("t6_rst_ir", 0, ir_o[0], 0);
        chk("t6_rst_addr", 0, addr_o[0], 0);
        cyc(0, 1, 0, 8'h00);
        send_str("TGCA\n", 2);
        chk("t6_len", 0, len_o[0], 4);

        for (int it = 0; it < 40; it++) begin
            int n = $urandom_range(0, 17);
            cyc(0, 1, $urandom_range(0, 1), alpha[$urandom_range(0, alpha.len() - 1)]);
            for (int j = 0; j < n; j++) begin
                logic [7:0] c = alpha[$urandom_range(0, alpha.len() - 1)];
                if (ph[0] != 1) break;
                if ($urandom_range(0, 15) == 0) cyc(0, 1, 1, c);
                else if ($urandom_range(0, 31) == 0) cyc(1, 0, 1, c);
                else send(c, $urandom_range(0, 2));
            end
            if (ph[0] == 1) send(8'h0A, $urandom_range(0, 2));
            repeat ($urandom_range(0, 2)) cyc(0, 0, $urandom_range(0, 1), "A");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
